// File: rtl/posit_mul_arb_if.sv
// rtl/posit_mul_arb_if.sv - requester, response and multiplier signals of posit_mul_arb
interface posit_mul_arb_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_nar;
  logic        rsp_zero;
  logic        rsp_timeout;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result;
  logic        mul_done;
  logic        mul_nar;
  logic        mul_zero;
  logic        mul_abort;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  mul_result, mul_done, mul_nar, mul_zero,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero,
    output rsp_timeout, mul_start, mul_a, mul_b, mul_abort
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output mul_result, mul_done, mul_nar, mul_zero,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero,
    input  rsp_timeout, mul_start, mul_a, mul_b, mul_abort
  );
endinterface

// File: rtl/posit_mul_arb.sv
// rtl/posit_mul_arb.sv - round-robin sharing of one multi-cycle posit multiplier by two requesters
module posit_mul_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             rst,
  posit_mul_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [15:0] wd_cnt;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        timeout_hit;

  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_nar_q;
  logic        rsp_zero_q;
  logic        rsp_timeout_q;

  // On a tie the requester that did not win last time is granted.
  assign grant0      = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1      = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign accept      = (state == IDLE) & (grant0 | grant1);
  assign timeout_hit = WD_EN & (state == BUSY) & ~bus.mul_done & (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (!bus.mul_done) state_nxt = BUSY;
      BUSY:    if (bus.mul_done || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are also gated by rst so they drop while reset is held.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.mul_start  = 1'b0;
    bus.mul_abort  = 1'b0;
    bus.rsp_valid  = 1'b0;
    if (!rst) begin
      bus.req0_ready = (state == IDLE) & grant0;
      bus.req1_ready = (state == IDLE) & grant1;
      bus.mul_start  = (state == ISSUE) & ~bus.mul_done;
      bus.mul_abort  = timeout_hit;
      bus.rsp_valid  = (state == RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= 1'b1;
      wd_cnt        <= 16'd0;
      mul_a_q       <= 32'd0;
      mul_b_q       <= 32'd0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_nar_q     <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        mul_a_q    <= grant1 ? bus.req1_a : bus.req0_a;
        mul_b_q    <= grant1 ? bus.req1_b : bus.req0_b;
        rsp_id_q   <= grant1;
        last_grant <= grant1;
      end
      if (state == ISSUE && !bus.mul_done) begin
        wd_cnt <= 16'd0;
      end
      if (state == BUSY) begin
        if (bus.mul_done) begin
          rsp_result_q  <= bus.mul_result;
          rsp_nar_q     <= bus.mul_nar;
          rsp_zero_q    <= bus.mul_zero;
          rsp_timeout_q <= 1'b0;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
          if (timeout_hit) begin
            rsp_result_q  <= 32'h8000_0000;
            rsp_nar_q     <= 1'b1;
            rsp_zero_q    <= 1'b0;
            rsp_timeout_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_nar     = rsp_nar_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_posit_mul_arb.sv
// tb/tb_posit_mul_arb.sv - directed self-checking bench for posit_mul_arb
module tb_posit_mul_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   start_cnt = 0;
  int   abort_cnt = 0;

  always #5 clk = ~clk;

  posit_mul_arb_if bus ();

  posit_mul_arb #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.mul_start === 1'b1) start_cnt++;
    if (bus.mul_abort === 1'b1) abort_cnt++;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic accept(input logic r0, input logic r1);
    settle();
    chk("acc_ready0", bus.req0_ready, r0);
    chk("acc_ready1", bus.req1_ready, r1);
    chk("acc_no_rsp", bus.rsp_valid, 1'b0);
    next();
  endtask

  // Entered at the start of the ISSUE cycle; returns at the start of the RESP cycle.
  task automatic mul_cycle(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] res,
                           input logic nar, input logic zero, input int lat);
    settle();
    chk("issue_start", bus.mul_start, 1'b1);
    chk("issue_a", bus.mul_a, ea);
    chk("issue_b", bus.mul_b, eb);
    chk("issue_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    next();
    for (int i = 1; i < lat; i++) begin
      settle();
      chk("busy_start", bus.mul_start, 1'b0);
      next();
    end
    bus.mul_done   = 1'b1;
    bus.mul_result = res;
    bus.mul_nar    = nar;
    bus.mul_zero   = zero;
    next();
    bus.mul_done = 1'b0;
    bus.mul_nar  = 1'b0;
    bus.mul_zero = 1'b0;
  endtask

  task automatic finish_rsp(input logic id, input logic [31:0] res, input logic nar,
                            input logic zero, input logic to);
    settle();
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_id", bus.rsp_id, id);
    chk("rsp_result", bus.rsp_result, res);
    chk("rsp_nar", bus.rsp_nar, nar);
    chk("rsp_zero", bus.rsp_zero, zero);
    chk("rsp_timeout", bus.rsp_timeout, to);
    next();
  endtask

  initial begin
    int          s0;
    int          a0;
    logic        eid;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] er;

    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h4000_0000;
    bus.req0_b     = 32'h4000_0000;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 32'h0;
    bus.req1_b     = 32'h0;
    bus.rsp_ready  = 1'b1;
    bus.mul_result = 32'h0;
    bus.mul_done   = 1'b0;
    bus.mul_nar    = 1'b0;
    bus.mul_zero   = 1'b0;

    // Reset state
    next();
    settle();
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_mul_start", bus.mul_start, 1'b0);
    chk("rst_mul_abort", bus.mul_abort, 1'b0);
    chk("rst_mul_a", bus.mul_a, 32'h0);
    chk("rst_mul_b", bus.mul_b, 32'h0);
    chk("rst_rsp_result", bus.rsp_result, 32'h0);
    chk("rst_rsp_flags", {bus.rsp_id, bus.rsp_nar, bus.rsp_zero, bus.rsp_timeout}, 4'h0);
    next();
    rst = 1'b0;

    // Single request 1.0 x 1.0, done 5 cycles after start
    s0 = start_cnt;
    accept(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    mul_cycle(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 5);
    finish_rsp(1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    settle();
    chk("single_idle", bus.rsp_valid, 1'b0);
    chk("single_starts", start_cnt - s0, 1);
    next();

    // Flags: NaR x 1.0 then 0 x 1.0, both from requester 1
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h8000_0000;
    bus.req1_b     = 32'h4000_0000;
    accept(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    mul_cycle(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    finish_rsp(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h0000_0000;
    accept(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    mul_cycle(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1, 3);
    finish_rsp(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Contention: both valid continuously, last winner was requester 1
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h5000_0000;
    bus.req0_b     = 32'h4000_0000;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h3000_0000;
    bus.req1_b     = 32'h3000_0000;
    for (int k = 0; k < 4; k++) begin
      eid = k[0];
      ea  = eid ? 32'h3000_0000 : 32'h5000_0000;
      eb  = eid ? 32'h3000_0000 : 32'h4000_0000;
      er  = eid ? 32'h2000_0000 : 32'h5000_0000;
      accept(~eid, eid);
      mul_cycle(ea, eb, er, 1'b0, 1'b0, 1 + k);
      finish_rsp(eid, er, 1'b0, 1'b0, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Stale done delays the next start; then hold the response under backpressure
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h4000_0000;
    bus.req0_b     = 32'h5000_0000;
    accept(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    settle();
    chk("stale_first_start", bus.mul_start, 1'b1);
    next();
    bus.mul_done   = 1'b1;
    bus.mul_result = 32'h5000_0000;
    next();
    finish_rsp(1'b0, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h3000_0000;
    bus.req1_b     = 32'h3000_0000;
    accept(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    settle();
    chk("stale_no_start", bus.mul_start, 1'b0);
    chk("stale_mul_a", bus.mul_a, 32'h3000_0000);
    next();
    bus.mul_done  = 1'b0;
    bus.rsp_ready = 1'b0;
    mul_cycle(32'h3000_0000, 32'h3000_0000, 32'h2000_0000, 1'b0, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_result", bus.rsp_result, 32'h2000_0000);
      chk("bp_id", bus.rsp_id, 1'b1);
      chk("bp_mul_a", bus.mul_a, 32'h3000_0000);
      next();
    end
    bus.rsp_ready = 1'b1;
    finish_rsp(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0);

    // Watchdog: multiplier never finishes
    a0 = abort_cnt;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h4000_0000;
    bus.req0_b     = 32'h4000_0000;
    accept(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    settle();
    chk("to_start", bus.mul_start, 1'b1);
    next();
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk("to_abort", bus.mul_abort, (i == 8) ? 1'b1 : 1'b0);
      chk("to_no_rsp", bus.rsp_valid, 1'b0);
      next();
    end
    finish_rsp(1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    chk("to_abort_count", abort_cnt - a0, 1);

    // Done arriving on the last watchdog cycle wins over the timeout
    a0 = abort_cnt;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h4000_0000;
    bus.req1_b     = 32'h4000_0000;
    accept(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    mul_cycle(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 8);
    finish_rsp(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    chk("edge_no_abort", abort_cnt - a0, 0);

    // Asynchronous reset in BUSY
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h5000_0000;
    bus.req1_b     = 32'h3000_0000;
    accept(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    settle();
    chk("ar_start", bus.mul_start, 1'b1);
    next();
    next();
    settle();
    chk("ar_pre_a", bus.mul_a, 32'h5000_0000);
    chk("ar_pre_id", bus.rsp_id, 1'b1);
    #1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h5000_0000;
    bus.req0_b     = 32'h4000_0000;
    bus.req1_valid = 1'b1;
    bus.mul_done   = 1'b1;
    rst            = 1'b1;
    #1;
    chk("ar_mul_a", bus.mul_a, 32'h0);
    chk("ar_mul_b", bus.mul_b, 32'h0);
    chk("ar_rsp_id", bus.rsp_id, 1'b0);
    chk("ar_outs", {bus.rsp_valid, bus.mul_start, bus.mul_abort, bus.req0_ready, bus.req1_ready}, 5'h0);
    next();
    next();
    rst          = 1'b0;
    bus.mul_done = 1'b0;
    accept(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mul_cycle(32'h5000_0000, 32'h4000_0000, 32'h5000_0000, 1'b0, 1'b0, 1);
    finish_rsp(1'b0, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ar_final_idle", bus.rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/posit_mul_arb.md
# posit_mul_arb

Round-robin arbiter and sequencer that shares one multi-cycle 32-bit posit multiplier (start/done handshake, NAR/ZERO flags) between two requesters. It sits between two client datapaths and the multiplier. It accepts operand pairs over valid/ready and issues exactly one multiply at a time. Each result is returned with the requester ID on a valid/ready response channel. A watchdog converts a hung multiply into a NaR response with a timeout flag.

## Interface
- TIMEOUT_CYCLES, 64, maximum cycles in BUSY waiting for mul_done; 0 disables the watchdog
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  32  requester 0 posit operands
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  32  posit product
- rsp_nar, rsp_zero  out  1  flags copied from the multiplier
- rsp_timeout  out  1  watchdog fired; result forced to NaR
- mul_start  out  1  start pulse to the multiplier
- mul_a, mul_b  out  32  multiplier operands
- mul_result  in  32  multiplier product
- mul_done, mul_nar, mul_zero  in  1  multiplier status
- mul_abort  out  1  one-cycle pulse on timeout, intended to reset or flush the multiplier

## Operation
- Four states: IDLE, ISSUE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready = grant_N & reqN_valid. This is combinational from state, valids and last_grant.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the requester not in last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - On a transfer, the design registers a, b and the ID into mul_a, mul_b and rsp_id, updates last_grant, and moves to ISSUE.
- ISSUE:
  - If mul_done=1 (stale done from the previous operation), mul_start=0 and the state stays ISSUE.
  - Otherwise mul_start=1 for exactly this cycle, then the state moves to BUSY with the watchdog counter cleared.
- BUSY:
  - On the first cycle mul_done=1, the design captures mul_result, mul_nar and mul_zero into the rsp_* registers, sets rsp_timeout=0, and moves to RESP.
  - Otherwise the counter increments. If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES-1 with mul_done=0, the design loads rsp_result=0x80000000, rsp_nar=1, rsp_zero=0, rsp_timeout=1, pulses mul_abort, and moves to RESP.
- RESP:
  - rsp_valid=1, and all rsp_* fields are held stable until rsp_valid & rsp_ready.
  - On that handshake the state moves to IDLE.
  - No request is accepted in ISSUE, BUSY or RESP; both req_ready are 0.
- mul_a and mul_b are held stable from the accept cycle until the next accept.
- The counter is 16 bits wide. TIMEOUT_CYCLES must be ≤ 65535.

## Timing
- Reset values: all outputs 0. rsp_result=0, mul_a=mul_b=0, state IDLE, last_grant=1, counter 0. Every output goes to 0 immediately on rst assertion, without waiting for a clock edge.
- Reset mid-operation aborts the operation. No response is produced for the accepted request, and mul_start and mul_abort deassert asynchronously.
- Latency, with acceptance at cycle T and no stale done:
  - mul_start is high in cycle T+1.
  - If mul_done is first high in cycle D, rsp_valid rises in cycle D+1.
  - With rsp_ready held high, the response handshake completes in cycle D+1 and IDLE is reached at D+2.
- Minimum request-to-request spacing: 4 cycles for one requester.
- Timeout: the mul_abort pulse and the transition to RESP happen on the clock edge ending BUSY cycle TIMEOUT_CYCLES. rsp_valid rises the next cycle.
- A request that stays valid without being granted is not dropped. The requester must keep valid and its operands stable until its ready is seen.

## Test plan
- Single request: req0 1.0×1.0 (0x40000000, 0x40000000), model done after 5 cycles -> exactly one mul_start pulse; rsp_valid with rsp_id=0, rsp_result=0x40000000, rsp_timeout=0.
- Contention: req0 and req1 both valid continuously, req0 0x50000000×0x40000000, req1 0x30000000×0x30000000 -> responses alternate with IDs 0,1,0,1, results 0x50000000 and 0x20000000, and neither requester is served twice in a row.
- Flags: NaR×1.0 and 0×1.0 issued as two separate requests -> first response has rsp_nar=1 and result 0x80000000; second has rsp_zero=1 and result 0x00000000.
- Backpressure and stale done: hold rsp_ready=0 for 10 cycles, and keep mul_done high for 3 cycles after the prior result -> response fields stay stable; the next mul_start is delayed until mul_done=0.
- Timeout: TIMEOUT_CYCLES=8, multiplier never asserts done -> mul_abort pulses once 8 cycles after the mul_start cycle; response has rsp_result=0x80000000, rsp_nar=1, rsp_timeout=1; the next request completes normally.
- Async reset while in BUSY -> all outputs 0 before the next clock edge; no response is produced; a request after release is served by req0 first on a tie.
